fifo_uart_tx: RTL

Downstream drain stage for the `fifo` block. Pops one data word whenever the FIFO is non-empty and enabled, then serializes it LSB-first on a single UART-style line: start bit, DW data bits, optional parity, 1 or 2 stop bits. Sits between the FIFO pop port and the chip's serial TX pin. Issues exactly one pop per frame, so the FIFO is never underflowed.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and constants for the FIFO-draining UART transmitter.
//   tx_state_e : frame sequencer states
//   PAR_*      : encodings of the PARITY parameter
// ---------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Free-running divider that marks the last clock cycle of each serial bit.
// Ports:
//   clk      in  : clock
//   rst      in  : synchronous active-high reset
//   clr      in  : hold the count at zero (used while no bit is on the line)
//   bit_tick out : high during the final cycle of a CLKS_PER_BIT period
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Wrap to zero at every bit boundary so the count never overflows.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops one word from an upstream FIFO per frame and sends it LSB-first as
// start bit, DW data bits, optional parity bit and 1 or 2 stop bits.
// Ports:
//   clk          in  : clock, all logic on posedge
//   rst          in  : synchronous active-high reset
//   enable       in  : permits starting new frames (sampled in IDLE only)
//   empty_flag   in  : FIFO empty status
//   pop_data     in  : FIFO read data, valid the cycle after pop
//   pop          out : registered one-cycle FIFO pop request
//   tx_o         out : registered serial line, idle high
//   busy_o       out : high from POP through the last stop cycle
//   frame_done_o out : one-cycle pulse in the IDLE cycle after STOP
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DW           = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          empty_flag,
    input  logic [DW-1:0] pop_data,
    output logic          pop,
    output logic          tx_o,
    output logic          busy_o,
    output logic          frame_done_o
);

    localparam int BIT_W = $clog2(DW + 1);

    tx_state_e        state_q;
    logic [DW-1:0]    shift_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             parity_q;
    logic             pop_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic             baud_clr;
    logic             bit_tick;

    // The baud counter only runs while a bit is being driven, so that START
    // always gets a full CLKS_PER_BIT period counted from LOAD.
    assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_POP) ||
                      (state_q == ST_LOAD);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            pop_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pop_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (enable && !empty_flag) begin
                        state_q <= ST_POP;
                        pop_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_POP: begin
                    // FIFO read data appears during the following cycle.
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_q   <= pop_data;
                    parity_q  <= (PARITY == PAR_ODD) ? ~(^pop_data) : (^pop_data);
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= ST_START;
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == BIT_W'(DW - 1)) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                ST_PAR: begin
                    if (bit_tick) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // The bit counter is reused to count stop bits.
                    if (bit_tick) begin
                        if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pop          = pop_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule
